// File: rtl/mccomp_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and word packing constants.
package mccomp_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_CNT_WIDTH = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRecv  = 2'd1,
        StWrite = 2'd2,
        StRun   = 2'd3
    } loader_state_e;

endpackage

// File: rtl/mccomp_loader_pack.sv
// Byte-to-word packer: shifts accepted bytes in MSB-first and flags the byte that completes a word.
module mccomp_loader_pack
    import mccomp_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_ready
);

    localparam logic [BYTE_CNT_WIDTH-1:0] LAST_BYTE = BYTE_CNT_WIDTH'(BYTES_PER_WORD - 1);

    logic [31:0]               shift_q;
    logic [BYTE_CNT_WIDTH-1:0] cnt_q;

    // Shift register and wrapping byte counter; clear restarts assembly for a new load.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clear) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (byte_en) begin
            shift_q <= {shift_q[23:0], byte_data};
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    // word_ready is combinational so the FSM can enter WRITE on the very next edge.
    assign word       = shift_q;
    assign word_ready = byte_en && (cnt_q == LAST_BYTE);

endmodule

// File: rtl/mccomp_loader.sv
// Runtime program loader: packs a byte stream into words, writes them to memory, and
// holds the CPU in reset until the final word of a load has been written.
module mccomp_loader
    import mccomp_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_rstn,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [31:0]           checksum
);

    localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

    loader_state_e         state_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [ADDR_WIDTH:0]   last_idx;
    logic                  start_seen;
    logic                  load_ok;
    logic                  pack_clear;
    logic                  byte_en;
    logic                  word_ready;
    logic [31:0]           word;

    // start only counts outside an active load; a zero or oversize count never reaches RECV
    assign start_seen = start && ((state_q == StIdle) || (state_q == StRun));
    assign load_ok    = (word_count != '0) && (word_count <= CAPACITY);
    assign pack_clear = start_seen && load_ok;
    assign byte_en    = byte_valid && byte_ready;
    assign last_idx   = count_q - (ADDR_WIDTH + 1)'(1);
    assign mem_addr   = idx_q;
    assign mem_wdata  = word;

    mccomp_loader_pack u_pack (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (pack_clear),
        .byte_en    (byte_en),
        .byte_data  (byte_data),
        .word       (word),
        .word_ready (word_ready)
    );

    // Load FSM with registered outputs, word index and running checksum.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            count_q    <= '0;
            idx_q      <= '0;
            checksum   <= '0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            cpu_rstn   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle, StRun: begin
                    if (start) begin
                        if (word_count > CAPACITY) begin
                            err      <= 1'b1;
                            state_q  <= StIdle;
                            cpu_rstn <= 1'b0;
                        end else if (word_count == '0) begin
                            err      <= 1'b0;
                            checksum <= '0;
                            state_q  <= StRun;
                            cpu_rstn <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            err        <= 1'b0;
                            checksum   <= '0;
                            count_q    <= word_count;
                            idx_q      <= '0;
                            state_q    <= StRecv;
                            byte_ready <= 1'b1;
                            busy       <= 1'b1;
                            cpu_rstn   <= 1'b0;
                        end
                    end
                end
                StRecv: begin
                    if (word_ready) begin
                        state_q    <= StWrite;
                        byte_ready <= 1'b0;
                        mem_we     <= 1'b1;
                    end
                end
                StWrite: begin
                    mem_we   <= 1'b0;
                    checksum <= checksum + word;
                    if ({1'b0, idx_q} == last_idx) begin
                        state_q  <= StRun;
                        busy     <= 1'b0;
                        cpu_rstn <= 1'b1;
                        done     <= 1'b1;
                    end else begin
                        idx_q      <= idx_q + 1'b1;
                        state_q    <= StRecv;
                        byte_ready <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mccomp_loader.sv
// Randomized bench for mccomp_loader with a transaction-level expected-write model.
module tb_mccomp_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [AW:0]   word_count;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_rstn;
    logic          busy;
    logic          done;
    logic          err;
    logic [31:0]   checksum;

    mccomp_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_rstn   (cpu_rstn),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // model state: bytes to send, expected writes in order, captured memory
    logic [7:0]  byte_q[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] exp_sum;
    logic [31:0] wr_mem[256];
    int          last_addr = -1;
    int          we_gap = 100;
    int          done_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // per-cycle compare against the model and the spec's state/output rules
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            chk("busy_iff_recv_or_write", 32'(busy), 32'(byte_ready | mem_we));
            chk("cpu_rstn_while_busy", 32'(cpu_rstn & busy), 32'd0);
            if (done) begin
                done_seen++;
                chk("cpu_rstn_at_done", 32'(cpu_rstn), 32'd1);
            end
            if (mem_we) begin
                chk("we_spacing_ge4", (we_gap >= 4) ? 32'd1 : 32'd0, 32'd1);
                chk("pending_write_exists", (exp_addr.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (exp_addr.size() > 0) begin
                    chk("write_addr", 32'(mem_addr), exp_addr.pop_front());
                    chk("write_data", mem_wdata, exp_data.pop_front());
                end
                wr_mem[mem_addr] = mem_wdata;
                last_addr = int'(mem_addr);
                we_gap = 0;
            end else begin
                we_gap++;
            end
        end
    end

    task automatic send_bytes(input int pct, input bit toggle, input bit inject);
        int  i = 0;
        int  guard = 0;
        int  limit = 20 * byte_q.size() + 50;
        bit  injected = 1'b0;
        while (i < byte_q.size() && guard < limit) begin
            @(negedge clk);
            start = 1'b0;
            if (inject && !injected && i == 2) begin
                start      = 1'b1;
                word_count = (AW + 1)'($urandom_range(0, 300));
                injected   = 1'b1;
            end
            byte_valid = toggle ? (guard % 2 == 0) : ($urandom_range(99) < pct);
            byte_data  = byte_valid ? byte_q[i] : 8'($urandom);
            if (byte_valid && byte_ready) i++;
            guard++;
        end
        chk("bytes_accepted", i, byte_q.size());
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        start      = 1'b0;
    endtask

    task automatic run_load(input int n, input int pct, input bit toggle, input bit inject);
        int d0;
        int k;
        logic [31:0] d;
        exp_sum = 32'd0;
        for (int w = 0; w < n; w++) begin
            d = {byte_q[4*w], byte_q[4*w+1], byte_q[4*w+2], byte_q[4*w+3]};
            exp_addr.push_back(32'(w));
            exp_data.push_back(d);
            exp_sum += d;
        end
        d0 = done_seen;
        @(negedge clk);
        start      = 1'b1;
        word_count = (AW + 1)'(n);
        @(negedge clk);
        start = 1'b0;
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_cpu_held", 32'(cpu_rstn), 32'd0);
        chk("load_err_clear", 32'(err), 32'd0);
        send_bytes(pct, toggle, inject);
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("run_cpu_released", 32'(cpu_rstn), 32'd1);
        chk("run_not_busy", 32'(busy), 32'd0);
        chk("checksum_model", checksum, exp_sum);
        chk("all_writes_seen", 32'(exp_addr.size()), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("done_count", 32'(done_seen - d0), 32'd1);
        exp_addr.delete();
        exp_data.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rstn       = 1'b0;
        start      = 1'b0;
        word_count = '0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        for (int a = 0; a < 256; a++) wr_mem[a] = 32'h0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_cpu_rstn", 32'(cpu_rstn), 32'd0);
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_checksum", checksum, 32'd0);

        // oversize count: sticky error, CPU stays in reset, no writes
        @(negedge clk);
        start      = 1'b1;
        word_count = (AW + 1)'(257);
        @(negedge clk);
        start = 1'b0;
        chk("oversize_err", 32'(err), 32'd1);
        chk("oversize_cpu", 32'(cpu_rstn), 32'd0);
        chk("oversize_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        chk("oversize_err_sticky", 32'(err), 32'd1);

        // zero-count load goes straight to RUN
        start      = 1'b1;
        word_count = '0;
        @(negedge clk);
        start = 1'b0;
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_cpu", 32'(cpu_rstn), 32'd1);
        chk("zero_err_clear", 32'(err), 32'd0);
        @(negedge clk);
        chk("zero_done_pulse", 32'(done), 32'd0);

        // directed two-word program, byte_valid held
        byte_q = '{8'h3C, 8'h08, 8'h00, 8'h01, 8'h00, 8'h08, 8'h40, 8'h80};
        run_load(2, 100, 1'b0, 1'b0);
        chk("lit_word0", wr_mem[0], 32'h3C080001);
        chk("lit_word1", wr_mem[1], 32'h00084080);
        chk("lit_checksum", checksum, 32'h3C104081);

        // same program, byte_valid toggling every other cycle
        wr_mem[0] = 32'h0;
        wr_mem[1] = 32'h0;
        run_load(2, 100, 1'b1, 1'b0);
        chk("toggle_word0", wr_mem[0], 32'h3C080001);
        chk("toggle_word1", wr_mem[1], 32'h00084080);
        chk("toggle_checksum", checksum, 32'h3C104081);

        // reload from RUN
        byte_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_load(1, 100, 1'b0, 1'b0);
        chk("lit_deadbeef", wr_mem[0], 32'hDEADBEEF);
        chk("lit_deadbeef_sum", checksum, 32'hDEADBEEF);

        // random loads; odd ones also pulse start mid-load, which must be ignored
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 8);
            byte_q.delete();
            for (int b = 0; b < 4 * n; b++) byte_q.push_back(8'($urandom));
            run_load(n, $urandom_range(30, 100), 1'b0, r[0]);
        end

        // full-capacity load ends exactly on the top address
        byte_q.delete();
        for (int b = 0; b < 1024; b++) byte_q.push_back(8'($urandom));
        run_load(256, 100, 1'b0, 1'b0);
        chk("full_last_addr", 32'(last_addr), 32'd255);
        chk("full_no_err", 32'(err), 32'd0);

        // abort mid-word with reset, then a fresh single-word load
        byte_q = '{8'hA1, 8'hA2};
        @(negedge clk);
        start      = 1'b1;
        word_count = (AW + 1)'(1);
        @(negedge clk);
        start = 1'b0;
        send_bytes(100, 1'b0, 1'b0);
        #2 rstn = 1'b0;
        #1;
        chk("abort_byte_ready", 32'(byte_ready), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cpu", 32'(cpu_rstn), 32'd0);
        chk("abort_mem_we", 32'(mem_we), 32'd0);
        chk("abort_mem_addr", 32'(mem_addr), 32'd0);
        chk("abort_mem_wdata", mem_wdata, 32'd0);
        chk("abort_checksum", checksum, 32'd0);
        chk("abort_done_err", 32'({done, err}), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_cpu_held", 32'(cpu_rstn), 32'd0);
        byte_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_load(1, 70, 1'b0, 1'b0);
        chk("after_abort_word", wr_mem[0], 32'h11223344);
        chk("after_abort_sum", checksum, 32'h11223344);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mccomp_loader.md
Name: mccomp_loader

Overview:
Runtime program loader for the multi-cycle CPU. It receives a byte stream over a valid/ready handshake, packs the bytes into 32-bit words and writes them into the unified instruction/data memory. While loading, it holds the CPU in reset, and it releases the CPU when the last word has been written. This replaces simulation-time memory preloading with a synthesizable path that can be driven by a UART receiver or a testbench.

Parameters:
ADDR_WIDTH, 8, word-address width of target memory; capacity = 2**ADDR_WIDTH words

Ports:
clk  input  1  system clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a load of word_count words
word_count  input  ADDR_WIDTH+1  number of words to load; sampled on accepted start
byte_valid  input  1  byte_data valid
byte_data  input  8  incoming byte; first byte of each word = bits 31:24
byte_ready  output  1  loader accepts byte this cycle
mem_we  output  1  memory write strobe, one cycle per word
mem_addr  output  ADDR_WIDTH  word address of write
mem_wdata  output  32  word being written
cpu_rstn  output  1  active-low reset to CPU core
busy  output  1  load in progress
done  output  1  one-cycle pulse when last word written
err  output  1  sticky; set on word_count > 2**ADDR_WIDTH
checksum  output  32  modulo-2^32 sum of all words written in current load

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE; byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rstn=0, busy=0, done=0, err=0, checksum=0, byte counter=0, word index=0.
- States:
  - IDLE: cpu_rstn=0.
  - RECV: byte_ready=1, busy=1, cpu_rstn=0.
  - WRITE: mem_we=1, busy=1, cpu_rstn=0.
  - RUN: cpu_rstn=1.
- IDLE, start=1:
  - word_count > 2**ADDR_WIDTH -> err=1, stay IDLE.
  - word_count = 0 -> RUN, done=1 next cycle.
  - Otherwise -> RECV: latch word_count, clear err, checksum, byte counter and word index.
- RECV: a byte is accepted when byte_valid & byte_ready.
  - It shifts into the assembly register MSB-first.
  - The byte counter wraps 0..3.
  - On the 4th accepted byte -> WRITE next cycle.
  - byte_valid with no accept (outside RECV) is ignored; no byte is lost inside RECV.
- WRITE: exactly one cycle.
  - mem_addr = word index, mem_wdata = assembled word, checksum += word (registered, visible the cycle after WRITE).
  - If word index = count-1 -> RUN, with done=1 for one cycle on entry.
  - Else word index +1 -> RECV.
- Throughput: max one word per 5 cycles (4 RECV + 1 WRITE). Latency from 4th byte accept to mem_we = 1 cycle.
- RUN: start=1 re-enters the load, identical to IDLE handling. cpu_rstn drops to 0 in the same cycle the state leaves RUN. The err path returns to IDLE and keeps the CPU in reset.
- start while busy (RECV/WRITE) is ignored.
- Word index never exceeds 2**ADDR_WIDTH-1; a full-capacity load writes the top address last. No wrap-around write occurs.
- Mid-load rstn assertion aborts immediately. Partial memory contents are not cleared; the CPU stays in reset until a new complete load.
- cpu_rstn is a registered output; no combinational path from any input.

Decomposition:
- Shared package: state encoding (IDLE/RECV/WRITE/RUN) and the byte-per-word constant (4), reused by a future register-dump block.
- One natural sub-module: mccomp_loader_pack. It holds the shift register, byte counter, word_ready flag and clear input.
- The FSM, address counter and checksum stay in the top module.

Test Plan:
- Reset then idle 10 cycles -> cpu_rstn=0, byte_ready=0, mem_we=0, err=0.
- start with word_count=2; send 0x3C,0x08,0x00,0x01 then 0x00,0x08,0x40,0x80 with byte_valid held -> mem_we at addr 0 with 0x3C080001, then addr 1 with 0x00084080; done pulse; cpu_rstn=1; checksum=0x3C104081.
- Same load with byte_valid toggled every other cycle -> identical writes and checksum; no duplicated or dropped bytes.
- start with word_count=257 (ADDR_WIDTH=8) -> err=1, no mem_we, cpu_rstn stays 0. A following start with word_count=0 -> done, RUN, err=0.
- In RUN, start with word_count=1 and bytes 0xDE,0xAD,0xBE,0xEF -> cpu_rstn falls the same cycle; write 0xDEADBEEF at addr 0; cpu_rstn rises with done.
- Assert rstn after 2 of 4 bytes -> all outputs at reset values immediately. A new 1-word load writes only its own 4 bytes to addr 0.
